// File: rtl/harmonic_accumulator.sv
// Harmonic additive-synthesis accumulator: multiplies each beat's sine by its level and
// sums the results into saturating left/right accumulators, then publishes one sample pair per frame.
module harmonic_accumulator #(
  parameter logic [7:0] MAX_HARMONICS = 8'd200,
  parameter logic [4:0] LEVEL_SHIFT   = 5'd16
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Frame_Start,
  input  logic               i_Valid,
  input  logic [7:0]         i_Harmonic,
  input  logic signed [15:0] i_Sine,
  input  logic [15:0]        i_Level,
  input  logic               i_Last,
  output logic               o_Ready,
  output logic signed [31:0] o_Sample_L,
  output logic signed [31:0] o_Sample_R,
  output logic               o_Start,
  output logic               o_Overflow,
  output logic [1:0]         o_Dbg_State
);

  // Handshake: a beat transfers on a rising edge where i_Valid && o_Ready, unless
  // i_Frame_Start is also high that cycle, in which case the beat is dropped.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   drain_cnt_q, drain_cnt_d;

  logic               s1_valid_q;
  logic               s1_route_q;
  logic signed [32:0] s1_p_q;
  logic signed [31:0] acc_l_q, acc_r_q;
  logic signed [31:0] sample_l_q, sample_r_q;
  logic               start_q;
  logic               overflow_q;

  logic               accept;
  logic               keep;
  logic signed [32:0] prod;
  logic signed [32:0] shifted;
  logic [31:0]        contrib;
  logic [31:0]        acc_sel;
  logic [32:0]        sum;
  logic [31:0]        acc_next;
  logic               sat;

  assign accept = i_Valid && o_Ready && !i_Frame_Start;
  assign keep   = (i_Harmonic < MAX_HARMONICS);
  assign prod   = $signed(33'(i_Sine)) * $signed(33'({1'b0, i_Level}));

  // State register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state logic; a frame start restarts accumulation from any state
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = 1'b0;
    case (state_q)
      IDLE:   state_d = IDLE;
      ACCUM:  if (accept && i_Last) state_d = DRAIN;
      DRAIN: begin
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) begin
          state_d     = OUTPUT;
          drain_cnt_d = 1'b0;
        end
      end
      OUTPUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_Frame_Start) begin
      state_d     = ACCUM;
      drain_cnt_d = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    o_Ready     = (state_q == ACCUM);
    o_Dbg_State = state_q;
  end

  // Stage 2 datapath: scaled product added to the routed accumulator, clamped at the rails
  always_comb begin
    shifted  = s1_p_q >>> LEVEL_SHIFT;
    contrib  = shifted[31:0];
    acc_sel  = s1_route_q ? acc_r_q : acc_l_q;
    sum      = {acc_sel[31], acc_sel} + {contrib[31], contrib};
    sat      = (sum[32] != sum[31]);
    acc_next = sum[31:0];
    if (sat) acc_next = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      s1_valid_q <= 1'b0;
      s1_route_q <= 1'b0;
      s1_p_q     <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // Discarded harmonics still complete the handshake but never reach stage 2
      s1_valid_q <= accept && keep;
      s1_route_q <= i_Harmonic[0];
      s1_p_q     <= prod;
      if (i_Frame_Start) begin
        acc_l_q    <= '0;
        acc_r_q    <= '0;
        overflow_q <= 1'b0;
      end else if (s1_valid_q) begin
        if (s1_route_q) acc_r_q <= acc_next;
        else            acc_l_q <= acc_next;
        if (sat) overflow_q <= 1'b1;
      end
      start_q <= (state_q == OUTPUT);
      if (state_q == OUTPUT) begin
        sample_l_q <= acc_l_q;
        sample_r_q <= acc_r_q;
      end
    end
  end

  assign o_Sample_L = sample_l_q;
  assign o_Sample_R = sample_r_q;
  assign o_Start    = start_q;
  assign o_Overflow = overflow_q;

endmodule
